// File: rtl/fp_add_pkg.sv
// Shared definitions for the dual-mode FP adder datapath.
// One 64-bit operand word carries either one double or two singles.
// Lane 1 of a single pair sits in [63:32] and lane 0 sits in [31:0].
package fp_add_pkg;

    localparam int DBL_EXP_W  = 11;
    localparam int DBL_FRAC_W = 52;
    localparam int SGL_EXP_W  = 8;
    localparam int SGL_FRAC_W = 23;

    // The packed 53-bit mantissa field puts lane 1 {h,frac23} at [52:29].
    // Lane 0 {h,frac23} sits at [23:0], and bits [28:24] are zero.
    localparam int LANE1_LSB  = 29;
    localparam int FRAC53_W   = DBL_FRAC_W + 1;
    localparam int EXP16_W    = 2 * SGL_EXP_W;

    localparam logic MODE_DBL = 1'b1;
    localparam logic MODE_SGL = 1'b0;

    // Every field view of one operand word; the mode selects which fields matter.
    typedef struct packed {
        logic [1:0]            sign;      // [1]=bit 63 (double / lane1), [0]=bit 31 (lane0)
        logic [DBL_EXP_W-1:0]  exp_dbl;
        logic [DBL_FRAC_W-1:0] frac_dbl;
        logic [SGL_EXP_W-1:0]  exp_l1;
        logic [SGL_FRAC_W-1:0] frac_l1;
        logic [SGL_EXP_W-1:0]  exp_l0;
        logic [SGL_FRAC_W-1:0] frac_l0;
    } fp_fields_t;

    // Slice a packed 64-bit operand into its double and single-lane fields.
    function automatic fp_fields_t fp_unpack(input logic [63:0] op);
        fp_fields_t f;
        f.sign     = {op[63], op[31]};
        f.exp_dbl  = op[62:52];
        f.frac_dbl = op[51:0];
        f.exp_l1   = op[62:55];
        f.frac_l1  = op[54:32];
        f.exp_l0   = op[30:23];
        f.frac_l0  = op[22:0];
        return f;
    endfunction

endpackage

// File: rtl/fp_lane_cmp.sv
// Magnitude compare of two IEEE-754 operands of configurable field widths.
// The compare ignores sign. Ties report b_gt_a=0, so operand a stays the large operand.
module fp_lane_cmp #(
    parameter int EXP_W  = 11,
    parameter int FRAC_W = 52
) (
    input  logic [EXP_W-1:0]  i_a_exp,
    input  logic [FRAC_W-1:0] i_a_frac,
    input  logic [EXP_W-1:0]  i_b_exp,
    input  logic [FRAC_W-1:0] i_b_frac,
    output logic              o_b_gt_a,
    output logic              o_special
);

    logic [EXP_W+FRAC_W-1:0] a_mag_s;
    logic [EXP_W+FRAC_W-1:0] b_mag_s;

    assign a_mag_s = {i_a_exp, i_a_frac};
    assign b_mag_s = {i_b_exp, i_b_frac};

    // Biased exponent concatenated with fraction orders magnitudes as an unsigned integer.
    always_comb begin
        o_b_gt_a  = (b_mag_s > a_mag_s);
        o_special = (&i_a_exp) | (&i_b_exp);
    end

endmodule

// File: rtl/fp_unpack_swap.sv
// Operand unpack/swap stage of the dual-mode FP adder.
// S1 unpacks fields, computes hidden bits, compares magnitudes and flags specials.
// S2 muxes the large and small operands per lane and packs them for the alignment stage.
// A single global stall freezes both stages while the output is held.
module fp_unpack_swap
    import fp_add_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic                 i_mode,
    input  logic                 i_sub,
    input  logic [63:0]          i_a,
    input  logic [63:0]          i_b,
    input  logic [TAG_W-1:0]     i_tag,
    input  logic                 i_ready,
    output logic                 e_valid,
    output logic                 e_mode,
    output logic [TAG_W-1:0]     e_tag,
    output logic [EXP16_W-1:0]   e_large_exp,
    output logic [EXP16_W-1:0]   e_small_exp,
    output logic [1:0]           e_large_hidden_bit,
    output logic [1:0]           e_small_hidden_bit,
    output logic [FRAC53_W-1:0]  e_large_frac53,
    output logic [FRAC53_W-1:0]  e_small_frac53,
    output logic [1:0]           e_res_sign,
    output logic [1:0]           e_eff_sub,
    output logic [1:0]           e_special,
    output logic [1:0]           e_swapped
);

    // ---------------------------------------------------------------
    // Handshake
    // ---------------------------------------------------------------
    logic stall_s;
    logic accept_s;

    logic e_valid_q, e_valid_d;

    assign stall_s  = e_valid_q & ~i_ready;
    assign o_ready  = ~stall_s;
    assign accept_s = i_valid & ~stall_s;

    // ---------------------------------------------------------------
    // Input unpack and lane compares
    // ---------------------------------------------------------------
    fp_fields_t a_f_s;
    fp_fields_t b_f_s;
    logic       swap_dbl_s, swap_l1_s, swap_l0_s;
    logic       spec_dbl_s, spec_l1_s, spec_l0_s;

    assign a_f_s = fp_unpack(i_a);
    assign b_f_s = fp_unpack(i_b);

    fp_lane_cmp #(.EXP_W(DBL_EXP_W), .FRAC_W(DBL_FRAC_W)) u_cmp_dbl (
        .i_a_exp   (a_f_s.exp_dbl),
        .i_a_frac  (a_f_s.frac_dbl),
        .i_b_exp   (b_f_s.exp_dbl),
        .i_b_frac  (b_f_s.frac_dbl),
        .o_b_gt_a  (swap_dbl_s),
        .o_special (spec_dbl_s)
    );

    fp_lane_cmp #(.EXP_W(SGL_EXP_W), .FRAC_W(SGL_FRAC_W)) u_cmp_l1 (
        .i_a_exp   (a_f_s.exp_l1),
        .i_a_frac  (a_f_s.frac_l1),
        .i_b_exp   (b_f_s.exp_l1),
        .i_b_frac  (b_f_s.frac_l1),
        .o_b_gt_a  (swap_l1_s),
        .o_special (spec_l1_s)
    );

    fp_lane_cmp #(.EXP_W(SGL_EXP_W), .FRAC_W(SGL_FRAC_W)) u_cmp_l0 (
        .i_a_exp   (a_f_s.exp_l0),
        .i_a_frac  (a_f_s.frac_l0),
        .i_b_exp   (b_f_s.exp_l0),
        .i_b_frac  (b_f_s.frac_l0),
        .o_b_gt_a  (swap_l0_s),
        .o_special (spec_l0_s)
    );

    // ---------------------------------------------------------------
    // Stage 1 registers
    // ---------------------------------------------------------------
    logic             s1_valid_q,   s1_valid_d;
    logic             s1_mode_q,    s1_mode_d;
    logic             s1_sub_q,     s1_sub_d;
    logic [TAG_W-1:0] s1_tag_q,     s1_tag_d;
    fp_fields_t       s1_a_q,       s1_a_d;
    fp_fields_t       s1_b_q,       s1_b_d;
    logic [1:0]       s1_a_hid_q,   s1_a_hid_d;
    logic [1:0]       s1_b_hid_q,   s1_b_hid_d;
    logic [1:0]       s1_swap_q,    s1_swap_d;
    logic [1:0]       s1_special_q, s1_special_d;

    // Stage 1 next state: capture an accepted operand pair and the per-lane compare results.
    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_mode_d    = s1_mode_q;
        s1_sub_d     = s1_sub_q;
        s1_tag_d     = s1_tag_q;
        s1_a_d       = s1_a_q;
        s1_b_d       = s1_b_q;
        s1_a_hid_d   = s1_a_hid_q;
        s1_b_hid_d   = s1_b_hid_q;
        s1_swap_d    = s1_swap_q;
        s1_special_d = s1_special_q;
        if (!stall_s) begin
            s1_valid_d = accept_s;
            if (accept_s) begin
                s1_mode_d = i_mode;
                s1_sub_d  = i_sub;
                s1_tag_d  = i_tag;
                s1_a_d    = a_f_s;
                s1_b_d    = b_f_s;
                // Lane 0 flags stay zero in double mode, so the later muxes can treat lanes uniformly.
                case (i_mode)
                    MODE_DBL: begin
                        s1_a_hid_d   = {(|a_f_s.exp_dbl), 1'b0};
                        s1_b_hid_d   = {(|b_f_s.exp_dbl), 1'b0};
                        s1_swap_d    = {swap_dbl_s, 1'b0};
                        s1_special_d = {spec_dbl_s, 1'b0};
                    end
                    MODE_SGL: begin
                        s1_a_hid_d   = {(|a_f_s.exp_l1), (|a_f_s.exp_l0)};
                        s1_b_hid_d   = {(|b_f_s.exp_l1), (|b_f_s.exp_l0)};
                        s1_swap_d    = {swap_l1_s, swap_l0_s};
                        s1_special_d = {spec_l1_s, spec_l0_s};
                    end
                    default: begin
                        s1_a_hid_d   = 2'b00;
                        s1_b_hid_d   = 2'b00;
                        s1_swap_d    = 2'b00;
                        s1_special_d = 2'b00;
                    end
                endcase
            end else begin
                s1_tag_d = s1_tag_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Stage 1 state update with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid_q   <= 1'b0;
            s1_mode_q    <= 1'b0;
            s1_sub_q     <= 1'b0;
            s1_tag_q     <= '0;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s1_a_hid_q   <= 2'b00;
            s1_b_hid_q   <= 2'b00;
            s1_swap_q    <= 2'b00;
            s1_special_q <= 2'b00;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_mode_q    <= s1_mode_d;
            s1_sub_q     <= s1_sub_d;
            s1_tag_q     <= s1_tag_d;
            s1_a_q       <= s1_a_d;
            s1_b_q       <= s1_b_d;
            s1_a_hid_q   <= s1_a_hid_d;
            s1_b_hid_q   <= s1_b_hid_d;
            s1_swap_q    <= s1_swap_d;
            s1_special_q <= s1_special_d;
        end
    end

    // ---------------------------------------------------------------
    // Stage 2: large/small selection and packing
    // ---------------------------------------------------------------
    fp_fields_t lg_f_s;
    fp_fields_t sm_f_s;
    logic [1:0] lg_hid_s;
    logic [1:0] sm_hid_s;

    // Route each lane's operands to the large/small slots using that lane's swap flag.
    always_comb begin
        lg_f_s.sign     = 2'b00;
        sm_f_s.sign     = 2'b00;
        lg_f_s.exp_dbl  = s1_swap_q[1] ? s1_b_q.exp_dbl  : s1_a_q.exp_dbl;
        sm_f_s.exp_dbl  = s1_swap_q[1] ? s1_a_q.exp_dbl  : s1_b_q.exp_dbl;
        lg_f_s.frac_dbl = s1_swap_q[1] ? s1_b_q.frac_dbl : s1_a_q.frac_dbl;
        sm_f_s.frac_dbl = s1_swap_q[1] ? s1_a_q.frac_dbl : s1_b_q.frac_dbl;
        lg_f_s.exp_l1   = s1_swap_q[1] ? s1_b_q.exp_l1   : s1_a_q.exp_l1;
        sm_f_s.exp_l1   = s1_swap_q[1] ? s1_a_q.exp_l1   : s1_b_q.exp_l1;
        lg_f_s.frac_l1  = s1_swap_q[1] ? s1_b_q.frac_l1  : s1_a_q.frac_l1;
        sm_f_s.frac_l1  = s1_swap_q[1] ? s1_a_q.frac_l1  : s1_b_q.frac_l1;
        lg_f_s.exp_l0   = s1_swap_q[0] ? s1_b_q.exp_l0   : s1_a_q.exp_l0;
        sm_f_s.exp_l0   = s1_swap_q[0] ? s1_a_q.exp_l0   : s1_b_q.exp_l0;
        lg_f_s.frac_l0  = s1_swap_q[0] ? s1_b_q.frac_l0  : s1_a_q.frac_l0;
        sm_f_s.frac_l0  = s1_swap_q[0] ? s1_a_q.frac_l0  : s1_b_q.frac_l0;
        lg_hid_s        = (s1_swap_q & s1_b_hid_q) | (~s1_swap_q & s1_a_hid_q);
        sm_hid_s        = (s1_swap_q & s1_a_hid_q) | (~s1_swap_q & s1_b_hid_q);
    end

    logic                e_mode_q,       e_mode_d;
    logic [TAG_W-1:0]    e_tag_q,        e_tag_d;
    logic [EXP16_W-1:0]  e_lg_exp_q,     e_lg_exp_d;
    logic [EXP16_W-1:0]  e_sm_exp_q,     e_sm_exp_d;
    logic [1:0]          e_lg_hid_q,     e_lg_hid_d;
    logic [1:0]          e_sm_hid_q,     e_sm_hid_d;
    logic [FRAC53_W-1:0] e_lg_frac_q,    e_lg_frac_d;
    logic [FRAC53_W-1:0] e_sm_frac_q,    e_sm_frac_d;
    logic [1:0]          e_res_sign_q,   e_res_sign_d;
    logic [1:0]          e_eff_sub_q,    e_eff_sub_d;
    logic [1:0]          e_special_q,    e_special_d;
    logic [1:0]          e_swapped_q,    e_swapped_d;
    logic [1:0]          res_sign_s;
    logic [1:0]          eff_sub_s;

    // Per-lane result sign and effective operation; lane 0 is masked in double mode below.
    always_comb begin
        for (int ln = 0; ln < 2; ln++) begin
            res_sign_s[ln] = s1_swap_q[ln] ? (s1_b_q.sign[ln] ^ s1_sub_q) : s1_a_q.sign[ln];
            eff_sub_s[ln]  = s1_a_q.sign[ln] ^ s1_b_q.sign[ln] ^ s1_sub_q;
        end
    end

    // Stage 2 next state: advance stage 1 into the output registers and pack per mode.
    always_comb begin
        e_valid_d    = e_valid_q;
        e_mode_d     = e_mode_q;
        e_tag_d      = e_tag_q;
        e_lg_exp_d   = e_lg_exp_q;
        e_sm_exp_d   = e_sm_exp_q;
        e_lg_hid_d   = e_lg_hid_q;
        e_sm_hid_d   = e_sm_hid_q;
        e_lg_frac_d  = e_lg_frac_q;
        e_sm_frac_d  = e_sm_frac_q;
        e_res_sign_d = e_res_sign_q;
        e_eff_sub_d  = e_eff_sub_q;
        e_special_d  = e_special_q;
        e_swapped_d  = e_swapped_q;
        if (!stall_s) begin
            e_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                e_mode_d    = s1_mode_q;
                e_tag_d     = s1_tag_q;
                e_lg_hid_d  = lg_hid_s;
                e_sm_hid_d  = sm_hid_s;
                e_special_d = s1_special_q;
                e_swapped_d = s1_swap_q;
                case (s1_mode_q)
                    MODE_DBL: begin
                        e_lg_exp_d   = {5'd0, lg_f_s.exp_dbl};
                        e_sm_exp_d   = {5'd0, sm_f_s.exp_dbl};
                        e_lg_frac_d  = {lg_hid_s[1], lg_f_s.frac_dbl};
                        e_sm_frac_d  = {sm_hid_s[1], sm_f_s.frac_dbl};
                        e_res_sign_d = {res_sign_s[1], 1'b0};
                        e_eff_sub_d  = {eff_sub_s[1], 1'b0};
                    end
                    MODE_SGL: begin
                        e_lg_exp_d   = {lg_f_s.exp_l1, lg_f_s.exp_l0};
                        e_sm_exp_d   = {sm_f_s.exp_l1, sm_f_s.exp_l0};
                        // The gap bits between the lanes stay zero so no alignment carry crosses lanes.
                        e_lg_frac_d  = {FRAC53_W{1'b0}};
                        e_sm_frac_d  = {FRAC53_W{1'b0}};
                        e_lg_frac_d[FRAC53_W-1:LANE1_LSB] = {lg_hid_s[1], lg_f_s.frac_l1};
                        e_sm_frac_d[FRAC53_W-1:LANE1_LSB] = {sm_hid_s[1], sm_f_s.frac_l1};
                        e_lg_frac_d[SGL_FRAC_W:0]         = {lg_hid_s[0], lg_f_s.frac_l0};
                        e_sm_frac_d[SGL_FRAC_W:0]         = {sm_hid_s[0], sm_f_s.frac_l0};
                        e_res_sign_d = res_sign_s;
                        e_eff_sub_d  = eff_sub_s;
                    end
                    default: begin
                        e_lg_exp_d   = {EXP16_W{1'b0}};
                        e_sm_exp_d   = {EXP16_W{1'b0}};
                        e_lg_frac_d  = {FRAC53_W{1'b0}};
                        e_sm_frac_d  = {FRAC53_W{1'b0}};
                        e_res_sign_d = 2'b00;
                        e_eff_sub_d  = 2'b00;
                    end
                endcase
            end else begin
                e_tag_d = e_tag_q;
            end
        end else begin
            e_valid_d = e_valid_q;
        end
    end

    // Output register update with synchronous reset clearing all data.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            e_valid_q    <= 1'b0;
            e_mode_q     <= 1'b0;
            e_tag_q      <= '0;
            e_lg_exp_q   <= '0;
            e_sm_exp_q   <= '0;
            e_lg_hid_q   <= 2'b00;
            e_sm_hid_q   <= 2'b00;
            e_lg_frac_q  <= '0;
            e_sm_frac_q  <= '0;
            e_res_sign_q <= 2'b00;
            e_eff_sub_q  <= 2'b00;
            e_special_q  <= 2'b00;
            e_swapped_q  <= 2'b00;
        end else begin
            e_valid_q    <= e_valid_d;
            e_mode_q     <= e_mode_d;
            e_tag_q      <= e_tag_d;
            e_lg_exp_q   <= e_lg_exp_d;
            e_sm_exp_q   <= e_sm_exp_d;
            e_lg_hid_q   <= e_lg_hid_d;
            e_sm_hid_q   <= e_sm_hid_d;
            e_lg_frac_q  <= e_lg_frac_d;
            e_sm_frac_q  <= e_sm_frac_d;
            e_res_sign_q <= e_res_sign_d;
            e_eff_sub_q  <= e_eff_sub_d;
            e_special_q  <= e_special_d;
            e_swapped_q  <= e_swapped_d;
        end
    end

    assign e_valid            = e_valid_q;
    assign e_mode             = e_mode_q;
    assign e_tag              = e_tag_q;
    assign e_large_exp        = e_lg_exp_q;
    assign e_small_exp        = e_sm_exp_q;
    assign e_large_hidden_bit = e_lg_hid_q;
    assign e_small_hidden_bit = e_sm_hid_q;
    assign e_large_frac53     = e_lg_frac_q;
    assign e_small_frac53     = e_sm_frac_q;
    assign e_res_sign         = e_res_sign_q;
    assign e_eff_sub          = e_eff_sub_q;
    assign e_special          = e_special_q;
    assign e_swapped          = e_swapped_q;

endmodule

// File: tb/tb_fp_unpack_swap.sv
// Directed self-checking bench for fp_unpack_swap.
module tb_fp_unpack_swap;

    logic        i_clk;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic        i_mode;
    logic        i_sub;
    logic [63:0] i_a;
    logic [63:0] i_b;
    logic [3:0]  i_tag;
    logic        i_ready;
    logic        e_valid;
    logic        e_mode;
    logic [3:0]  e_tag;
    logic [15:0] e_large_exp;
    logic [15:0] e_small_exp;
    logic [1:0]  e_large_hidden_bit;
    logic [1:0]  e_small_hidden_bit;
    logic [52:0] e_large_frac53;
    logic [52:0] e_small_frac53;
    logic [1:0]  e_res_sign;
    logic [1:0]  e_eff_sub;
    logic [1:0]  e_special;
    logic [1:0]  e_swapped;

    int n_tests;
    int n_fail;

    fp_unpack_swap #(.TAG_W(4)) dut (
        .i_clk              (i_clk),
        .i_rst              (i_rst),
        .i_valid            (i_valid),
        .o_ready            (o_ready),
        .i_mode             (i_mode),
        .i_sub              (i_sub),
        .i_a                (i_a),
        .i_b                (i_b),
        .i_tag              (i_tag),
        .i_ready            (i_ready),
        .e_valid            (e_valid),
        .e_mode             (e_mode),
        .e_tag              (e_tag),
        .e_large_exp        (e_large_exp),
        .e_small_exp        (e_small_exp),
        .e_large_hidden_bit (e_large_hidden_bit),
        .e_small_hidden_bit (e_small_hidden_bit),
        .e_large_frac53     (e_large_frac53),
        .e_small_frac53     (e_small_frac53),
        .e_res_sign         (e_res_sign),
        .e_eff_sub          (e_eff_sub),
        .e_special          (e_special),
        .e_swapped          (e_swapped)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Present one transaction for a single cycle, then wait until it reaches the outputs.
    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic mode,
                         input logic sub, input logic [3:0] tag);
        i_a     = a;
        i_b     = b;
        i_mode  = mode;
        i_sub   = sub;
        i_tag   = tag;
        i_valid = 1'b1;
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        check_eq("latency_not_early", {63'd0, e_valid}, 64'd0);
        @(posedge i_clk); #1;
        check_eq("latency_valid", {63'd0, e_valid}, 64'd1);
        check_eq("tag", {60'd0, e_tag}, {60'd0, tag});
        check_eq("mode", {63'd0, e_mode}, {63'd0, mode});
    endtask

    task automatic drain();
        i_valid = 1'b0;
        i_ready = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
    endtask

    logic [52:0] f53_exp;
    logic [10:0] e11;
    int          sent;
    int          rcv;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_mode  = 1'b0;
        i_sub   = 1'b0;
        i_a     = 64'd0;
        i_b     = 64'd0;
        i_tag   = 4'd0;
        i_ready = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        check_eq("rst_e_valid", {63'd0, e_valid}, 64'd0);
        check_eq("rst_o_ready", {63'd0, o_ready}, 64'd1);
        check_eq("rst_large_exp", {48'd0, e_large_exp}, 64'd0);
        check_eq("rst_large_frac", {11'd0, e_large_frac53}, 64'd0);
        check_eq("rst_swapped", {62'd0, e_swapped}, 64'd0);
        i_rst = 1'b0;

        // Double 1.0 + 2.0: b is larger.
        issue(64'h3FF0000000000000, 64'h4000000000000000, 1'b1, 1'b0, 4'h1);
        f53_exp = 53'd1 << 52;
        check_eq("d12_swapped", {62'd0, e_swapped}, 64'h2);
        check_eq("d12_lexp", {48'd0, e_large_exp}, 64'h0400);
        check_eq("d12_sexp", {48'd0, e_small_exp}, 64'h03FF);
        check_eq("d12_lfrac", {11'd0, e_large_frac53}, {11'd0, f53_exp});
        check_eq("d12_sfrac", {11'd0, e_small_frac53}, {11'd0, f53_exp});
        check_eq("d12_effsub", {62'd0, e_eff_sub}, 64'h0);
        check_eq("d12_lhid", {62'd0, e_large_hidden_bit}, 64'h2);
        check_eq("d12_sign", {62'd0, e_res_sign}, 64'h0);

        // Singles: lane1 2.0 vs 1.0 (no swap), lane0 1.0 vs 3.0 (swap).
        issue({32'h40000000, 32'h3F800000}, {32'h3F800000, 32'h40400000}, 1'b0, 1'b0, 4'h2);
        f53_exp = (53'h800000 << 29) | 53'hC00000;
        check_eq("s_swapped", {62'd0, e_swapped}, 64'h1);
        check_eq("s_lexp", {48'd0, e_large_exp}, 64'h8080);
        check_eq("s_sexp", {48'd0, e_small_exp}, 64'h7F7F);
        check_eq("s_lfrac", {11'd0, e_large_frac53}, {11'd0, f53_exp});
        f53_exp = (53'h800000 << 29) | 53'h800000;
        check_eq("s_sfrac", {11'd0, e_small_frac53}, {11'd0, f53_exp});
        check_eq("s_hid", {60'd0, e_large_hidden_bit, e_small_hidden_bit}, 64'hF);

        // Denormal lane0; lane1 is an exact tie of zeros and must not swap.
        issue({32'h0, 32'h00000001}, {32'h0, 32'h3F800000}, 1'b0, 1'b0, 4'h3);
        check_eq("dn_swapped", {62'd0, e_swapped}, 64'h1);
        check_eq("dn_shid", {62'd0, e_small_hidden_bit}, 64'h0);
        check_eq("dn_lhid", {62'd0, e_large_hidden_bit}, 64'h1);
        check_eq("dn_sexp", {48'd0, e_small_exp}, 64'h0);
        check_eq("dn_lexp", {48'd0, e_large_exp}, 64'h007F);
        check_eq("dn_sfrac", {11'd0, e_small_frac53}, 64'h1);

        // Double 1.0 - 3.0: swap, result negative, effective subtract.
        issue(64'h3FF0000000000000, 64'h4008000000000000, 1'b1, 1'b1, 4'h4);
        check_eq("sub_sign", {62'd0, e_res_sign}, 64'h2);
        check_eq("sub_effsub", {62'd0, e_eff_sub}, 64'h2);
        check_eq("sub_swapped", {62'd0, e_swapped}, 64'h2);
        check_eq("sub_special", {62'd0, e_special}, 64'h0);

        // Double NaN operand.
        issue(64'h3FF0000000000000, 64'h7FF8000000000000, 1'b1, 1'b0, 4'h5);
        check_eq("nan_special", {62'd0, e_special}, 64'h2);
        check_eq("nan_lexp", {48'd0, e_large_exp}, 64'h07FF);

        // Double tie 2.0 - 2.0: no swap, sign from a.
        issue(64'h4000000000000000, 64'h4000000000000000, 1'b1, 1'b1, 4'h6);
        check_eq("tie_swapped", {62'd0, e_swapped}, 64'h0);
        check_eq("tie_sign", {62'd0, e_res_sign}, 64'h0);
        check_eq("tie_effsub", {62'd0, e_eff_sub}, 64'h2);

        // Singles with signs: lane1 -1 + 2 (swap, +), lane0 -3 + 1 (no swap, -); lane0 Inf in a.
        issue({32'hBF800000, 32'hC0400000}, {32'h40000000, 32'h3F800000}, 1'b0, 1'b0, 4'h7);
        check_eq("sg_swapped", {62'd0, e_swapped}, 64'h2);
        check_eq("sg_sign", {62'd0, e_res_sign}, 64'h1);
        check_eq("sg_effsub", {62'd0, e_eff_sub}, 64'h3);
        issue({32'h3F800000, 32'h7F800000}, {32'h3F800000, 32'h3F800000}, 1'b0, 1'b0, 4'h8);
        check_eq("sg_special", {62'd0, e_special}, 64'h1);

        // Stall: three back-to-back inputs with the output held for three cycles.
        drain();
        i_ready = 1'b0;
        sent = 0;
        rcv  = 0;
        for (int c = 0; c < 20 && rcv < 3; c++) begin
            i_ready = (c >= 5);
            if (sent < 3) begin
                e11     = 11'h3F1 + 11'(sent);
                i_valid = 1'b1;
                i_mode  = 1'b1;
                i_sub   = 1'b0;
                i_a     = {1'b0, e11, 52'd0};
                i_b     = 64'd0;
                i_tag   = 4'(sent + 1);
            end else begin
                i_valid = 1'b0;
            end
            #1;
            if (c >= 2 && c <= 4) begin
                check_eq("stall_o_ready", {63'd0, o_ready}, 64'd0);
                check_eq("stall_e_valid", {63'd0, e_valid}, 64'd1);
                check_eq("stall_tag", {60'd0, e_tag}, 64'd1);
                check_eq("stall_lexp", {48'd0, e_large_exp}, 64'h03F1);
            end
            if (e_valid && i_ready) begin
                check_eq("order_tag", {60'd0, e_tag}, 64'(rcv + 1));
                check_eq("order_lexp", {48'd0, e_large_exp}, 64'(16'h03F1 + 16'(rcv)));
                rcv++;
            end
            if (i_valid && o_ready) sent++;
            @(posedge i_clk); #1;
        end
        check_eq("stall_rcv_count", 64'(rcv), 64'd3);
        check_eq("stall_sent_count", 64'(sent), 64'd3);
        check_eq("stall_drained", {63'd0, e_valid}, 64'd0);

        // Reset with two transactions in flight.
        drain();
        i_valid = 1'b1;
        i_mode  = 1'b1;
        i_a     = 64'h3FF0000000000000;
        i_b     = 64'h4000000000000000;
        i_tag   = 4'hA;
        @(posedge i_clk); #1;
        i_tag   = 4'hB;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        check_eq("pre_rst_valid", {63'd0, e_valid}, 64'd1);
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        check_eq("mid_rst_e_valid", {63'd0, e_valid}, 64'd0);
        check_eq("mid_rst_o_ready", {63'd0, o_ready}, 64'd1);
        check_eq("mid_rst_lexp", {48'd0, e_large_exp}, 64'd0);
        @(posedge i_clk); #1;
        check_eq("mid_rst_flushed", {63'd0, e_valid}, 64'd0);
        issue(64'h4000000000000000, 64'h3FF0000000000000, 1'b1, 1'b0, 4'hC);
        check_eq("post_rst_swapped", {62'd0, e_swapped}, 64'h0);
        check_eq("post_rst_lexp", {48'd0, e_large_exp}, 64'h0400);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
